// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port synchronous data memory: CPU has priority, debug is force-granted after STARVE_LIMIT denials.
// Optional grant statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_req_ready,
  output logic                  cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
  input  logic                  dbg_req_valid,
  input  logic                  dbg_req_we,
  input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
  input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
  output logic                  dbg_req_ready,
  output logic                  dbg_rsp_valid,
  output logic [DATA_WIDTH-1:0] dbg_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic [15:0]           stat_cpu_grants,
  output logic [15:0]           stat_dbg_grants
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  function automatic logic [3:0] sat_inc_starve(input logic [3:0] v);
    return (v >= LIMIT) ? LIMIT : v + 4'd1;
  endfunction

  function automatic logic [15:0] sat_inc_stat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [3:0]            starve_cnt;
  logic [3:0]            starve_nxt;
  owner_t                rsp_owner_p1;
  owner_t                owner_nxt;
  logic                  force_dbg;
  logic                  grant_cpu;
  logic                  grant_dbg;
  logic [DATA_WIDTH-1:0] cpu_rdata_p1;
  logic [DATA_WIDTH-1:0] dbg_rdata_p1;

  always_comb begin
    grant_cpu  = 1'b0;
    grant_dbg  = 1'b0;
    force_dbg  = dbg_req_valid && (starve_cnt == LIMIT);
    if (!nreset) begin
      if (force_dbg)          grant_dbg = 1'b1;
      else if (cpu_req_valid) grant_cpu = 1'b1;
      else if (dbg_req_valid) grant_dbg = 1'b1;
    end

    mem_addr = grant_dbg ? dbg_req_addr  : cpu_req_addr;
    mem_wd   = grant_dbg ? dbg_req_wdata : cpu_req_wdata;
    mem_we   = (grant_cpu && cpu_req_we) || (grant_dbg && dbg_req_we);

    starve_nxt = 4'd0;
    if (dbg_req_valid && !grant_dbg) starve_nxt = sat_inc_starve(starve_cnt);

    owner_nxt = OWN_NONE;
    if (grant_cpu && !cpu_req_we)      owner_nxt = OWN_CPU;
    else if (grant_dbg && !dbg_req_we) owner_nxt = OWN_DBG;
  end

  assign cpu_req_ready = grant_cpu;
  assign dbg_req_ready = grant_dbg;

  // Response stage: memory data arrives one cycle after the grant; masked while in reset.
  assign cpu_rsp_valid = !nreset && (rsp_owner_p1 == OWN_CPU);
  assign dbg_rsp_valid = !nreset && (rsp_owner_p1 == OWN_DBG);
  assign cpu_rsp_rdata = cpu_rsp_valid ? mem_rd : cpu_rdata_p1;
  assign dbg_rsp_rdata = dbg_rsp_valid ? mem_rd : dbg_rdata_p1;

  always_ff @(posedge clk) begin
    if (nreset) begin
      starve_cnt   <= 4'd0;
      rsp_owner_p1 <= OWN_NONE;
      cpu_rdata_p1 <= '0;
      dbg_rdata_p1 <= '0;
    end else begin
      starve_cnt   <= starve_nxt;
      rsp_owner_p1 <= owner_nxt;
      if (cpu_rsp_valid) cpu_rdata_p1 <= mem_rd;
      if (dbg_rsp_valid) dbg_rdata_p1 <= mem_rd;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] cpu_grants;
  logic [15:0] dbg_grants;

  always_ff @(posedge clk) begin
    if (nreset) begin
      cpu_grants <= 16'h0000;
      dbg_grants <= 16'h0000;
    end else begin
      if (grant_cpu) cpu_grants <= sat_inc_stat(cpu_grants);
      if (grant_dbg) dbg_grants <= sat_inc_stat(dbg_grants);
    end
  end

  assign stat_cpu_grants = cpu_grants;
  assign stat_dbg_grants = dbg_grants;
`else
  assign stat_cpu_grants = 16'h0000;
  assign stat_dbg_grants = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, starvation sequence, and randomized traffic vs. a reference model.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic          cpu_req_valid, cpu_req_we, cpu_req_ready, cpu_rsp_valid;
  logic [AW-1:0] cpu_req_addr;
  logic [DW-1:0] cpu_req_wdata, cpu_rsp_rdata;
  logic          dbg_req_valid, dbg_req_we, dbg_req_ready, dbg_rsp_valid;
  logic [AW-1:0] dbg_req_addr;
  logic [DW-1:0] dbg_req_wdata, dbg_rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wd, mem_rd;
  logic [15:0]   stat_cpu_grants, stat_dbg_grants;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .nreset(nreset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_ready(cpu_req_ready),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
    .dbg_req_valid(dbg_req_valid), .dbg_req_we(dbg_req_we), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata), .dbg_req_ready(dbg_req_ready),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .stat_cpu_grants(stat_cpu_grants), .stat_dbg_grants(stat_dbg_grants)
  );

  // Single-port synchronous memory with 1-cycle read latency.
  logic [DW-1:0] mem [8];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
    mem_rd <= mem[mem_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int            starve = 0;
  logic          pend_v = 1'b0;
  logic          pend_dbg = 1'b0;
  logic [DW-1:0] pend_d = '0;
  logic [DW-1:0] held_c = '0;
  logic [DW-1:0] held_d = '0;
  logic [DW-1:0] ref_mem [8];
  int            cnt_c = 0;
  int            cnt_d = 0;
  logic          model_chk = 1'b0;

  // Sampled DUT outputs of the most recent cycle
  logic          s_cr, s_dr, s_we, s_crv, s_drv;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wd, s_crd, s_drd;

  task automatic cycle(input logic r,
                       input logic cv, input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cw,
                       input logic dv, input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dw);
    logic gd, gc, e_crv, e_drv;
    logic [DW-1:0] e_crd, e_drd;
    @(posedge clk);
    #1;
    nreset = r;
    cpu_req_valid = cv; cpu_req_we = cwe; cpu_req_addr = ca; cpu_req_wdata = cw;
    dbg_req_valid = dv; dbg_req_we = dwe; dbg_req_addr = da; dbg_req_wdata = dw;
    #1;
    s_cr = cpu_req_ready; s_dr = dbg_req_ready; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wd;
    s_crv = cpu_rsp_valid; s_crd = cpu_rsp_rdata; s_drv = dbg_rsp_valid; s_drd = dbg_rsp_rdata;

    gd = !r && dv && ((starve == SL) || !cv);
    gc = !r && cv && !gd;
    e_crv = !r && pend_v && !pend_dbg;
    e_drv = !r && pend_v && pend_dbg;
    e_crd = e_crv ? pend_d : held_c;
    e_drd = e_drv ? pend_d : held_d;
    if (model_chk) begin
      chk("rnd_cpu_ready", 32'(s_cr), 32'(gc));
      chk("rnd_dbg_ready", 32'(s_dr), 32'(gd));
      chk("rnd_mem_we", 32'(s_we), 32'((gc && cwe) || (gd && dwe)));
      chk("rnd_mem_addr", 32'(s_addr), 32'(gd ? da : ca));
      if ((gc && cwe) || (gd && dwe)) chk("rnd_mem_wd", s_wd, gd ? dw : cw);
      chk("rnd_cpu_rsp_valid", 32'(s_crv), 32'(e_crv));
      chk("rnd_dbg_rsp_valid", 32'(s_drv), 32'(e_drv));
      chk("rnd_cpu_rsp_rdata", s_crd, e_crd);
      chk("rnd_dbg_rsp_rdata", s_drd, e_drd);
    end

    if (r) begin
      starve = 0; pend_v = 1'b0; held_c = '0; held_d = '0; cnt_c = 0; cnt_d = 0;
    end else begin
      if (e_crv) held_c = pend_d;
      if (e_drv) held_d = pend_d;
      starve = (dv && !gd) ? ((starve < SL) ? starve + 1 : SL) : 0;
      pend_v = (gc && !cwe) || (gd && !dwe);
      pend_dbg = gd;
      pend_d = gd ? ref_mem[da] : ref_mem[ca];
      if (gc && cwe) ref_mem[ca] = cw;
      if (gd && dwe) ref_mem[da] = dw;
      if (gc && cnt_c < 65535) cnt_c++;
      if (gd && cnt_d < 65535) cnt_d++;
    end
  endtask

  task automatic chk_stats(input string nm);
`ifdef DMEM_ARB_STATS_EN
    chk({nm, "_stat_cpu"}, 32'(stat_cpu_grants), 32'(cnt_c));
    chk({nm, "_stat_dbg"}, 32'(stat_dbg_grants), 32'(cnt_d));
`else
    chk({nm, "_stat_cpu"}, 32'(stat_cpu_grants), 32'h0);
    chk({nm, "_stat_dbg"}, 32'(stat_dbg_grants), 32'h0);
`endif
  endtask

  typedef struct {
    logic          rst;
    logic          cv, cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cw;
    logic          dv, dwe;
    logic [AW-1:0] da;
    logic [DW-1:0] dw;
    logic          e_cr, e_dr, e_we;
    logic [AW-1:0] e_addr;
    logic          e_crv;
    logic [DW-1:0] e_crd;
    logic          e_drv;
    logic [DW-1:0] e_drd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic          c_v, c_we, d_v, d_we;
    logic [AW-1:0] c_a, d_a;
    logic [DW-1:0] c_w, d_w;
    logic          r;

    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    nreset = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    dbg_req_valid = 1'b0; dbg_req_we = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;

    // Reset with both requesters active: readies and write enable gated off.
    cycle(1, 1, 1, 3'd1, 32'h1, 1, 1, 3'd2, 32'h2);
    chk("rst_cpu_ready", 32'(s_cr), 32'h0);
    chk("rst_dbg_ready", 32'(s_dr), 32'h0);
    chk("rst_mem_we", 32'(s_we), 32'h0);
    cycle(0, 0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
    chk("rst_cpu_rsp_valid", 32'(s_crv), 32'h0);
    chk("rst_dbg_rsp_valid", 32'(s_drv), 32'h0);
    chk("rst_cpu_rdata", s_crd, 32'h0);
    chk("rst_dbg_rdata", s_drd, 32'h0);
    chk_stats("rst");

    // Preload memory through the debug port: mem[i] = 10 + i.
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 3'd0, 32'h0, 1, 1, AW'(i), DW'(10 + i));
      chk("preload_dbg_ready", 32'(s_dr), 32'h1);
      chk("preload_mem_we", 32'(s_we), 32'h1);
      chk("preload_mem_addr", 32'(s_addr), 32'(i));
    end

    //            rst cv cwe ca    cw            dv dwe da    dw            cr dr we addr  crv crd           drv drd
    tbl[0]  = '{0, 0, 0, 3'd0, 32'h0,        1, 1, 3'd3, 32'hDEADBEEF, 0, 1, 1, 3'd3, 0, 32'h0,        0, 32'h0};
    tbl[1]  = '{0, 1, 0, 3'd3, 32'h0,        0, 0, 3'd0, 32'h0,        1, 0, 0, 3'd3, 0, 32'h0,        0, 32'h0};
    tbl[2]  = '{0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        0, 0, 0, 3'd0, 1, 32'hDEADBEEF, 0, 32'h0};
    tbl[3]  = '{0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        0, 0, 0, 3'd0, 0, 32'hDEADBEEF, 0, 32'h0};
    tbl[4]  = '{0, 1, 0, 3'd0, 32'h0,        1, 0, 3'd1, 32'h0,        1, 0, 0, 3'd0, 0, 32'hDEADBEEF, 0, 32'h0};
    tbl[5]  = '{0, 1, 0, 3'd1, 32'h0,        1, 0, 3'd1, 32'h0,        1, 0, 0, 3'd1, 1, 32'd10,       0, 32'h0};
    tbl[6]  = '{0, 1, 0, 3'd2, 32'h0,        1, 0, 3'd1, 32'h0,        1, 0, 0, 3'd2, 1, 32'd11,       0, 32'h0};
    tbl[7]  = '{0, 0, 0, 3'd0, 32'h0,        1, 0, 3'd1, 32'h0,        0, 1, 0, 3'd1, 1, 32'd12,       0, 32'h0};
    tbl[8]  = '{0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        0, 0, 0, 3'd0, 0, 32'd12,       1, 32'd11};
    tbl[9]  = '{0, 1, 1, 3'd5, 32'h55AA55AA, 0, 0, 3'd0, 32'h0,        1, 0, 1, 3'd5, 0, 32'd12,       0, 32'd11};
    tbl[10] = '{0, 0, 0, 3'd0, 32'h0,        1, 0, 3'd5, 32'h0,        0, 1, 0, 3'd5, 0, 32'd12,       0, 32'd11};
    tbl[11] = '{0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        0, 0, 0, 3'd0, 0, 32'd12,       1, 32'h55AA55AA};
    tbl[12] = '{0, 1, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        1, 0, 0, 3'd0, 0, 32'd12,       0, 32'h55AA55AA};
    tbl[13] = '{1, 1, 0, 3'd0, 32'h0,        1, 1, 3'd4, 32'h99,       0, 0, 0, 3'd0, 0, 32'd12,       0, 32'h55AA55AA};
    tbl[14] = '{0, 0, 0, 3'd0, 32'h0,        0, 0, 3'd0, 32'h0,        0, 0, 0, 3'd0, 0, 32'h0,        0, 32'h0};
    tbl[15] = '{0, 1, 0, 3'd0, 32'h0,        1, 0, 3'd1, 32'h0,        1, 0, 0, 3'd0, 0, 32'h0,        0, 32'h0};

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].rst, tbl[i].cv, tbl[i].cwe, tbl[i].ca, tbl[i].cw,
            tbl[i].dv, tbl[i].dwe, tbl[i].da, tbl[i].dw);
      chk($sformatf("tbl%0d_cpu_ready", i), 32'(s_cr), 32'(tbl[i].e_cr));
      chk($sformatf("tbl%0d_dbg_ready", i), 32'(s_dr), 32'(tbl[i].e_dr));
      chk($sformatf("tbl%0d_mem_we", i), 32'(s_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_mem_addr", i), 32'(s_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_cpu_rsp_valid", i), 32'(s_crv), 32'(tbl[i].e_crv));
      chk($sformatf("tbl%0d_cpu_rsp_rdata", i), s_crd, tbl[i].e_crd);
      chk($sformatf("tbl%0d_dbg_rsp_valid", i), 32'(s_drv), 32'(tbl[i].e_drv));
      chk($sformatf("tbl%0d_dbg_rsp_rdata", i), s_drd, tbl[i].e_drd);
    end
    chk_stats("tbl");

    // Starvation: CPU loads every cycle, debug load to addr 2 always pending.
    cycle(0, 0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
    for (int k = 1; k <= 2 * (SL + 1); k++) begin
      cycle(0, 1, 0, 3'd0, 32'h0, 1, 0, 3'd2, 32'h0);
      if (k % (SL + 1) == 0) begin
        chk($sformatf("starve%0d_cpu_ready", k), 32'(s_cr), 32'h0);
        chk($sformatf("starve%0d_dbg_ready", k), 32'(s_dr), 32'h1);
        chk($sformatf("starve%0d_mem_addr", k), 32'(s_addr), 32'd2);
      end else begin
        chk($sformatf("starve%0d_cpu_ready", k), 32'(s_cr), 32'h1);
        chk($sformatf("starve%0d_dbg_ready", k), 32'(s_dr), 32'h0);
      end
      if (k == SL + 2) begin
        chk("starve_dbg_rsp_valid", 32'(s_drv), 32'h1);
        chk("starve_dbg_rsp_rdata", s_drd, 32'd12);
        chk("starve_cpu_rsp_valid", 32'(s_crv), 32'h0);
      end
    end
    cycle(0, 0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);

    // Randomized traffic; unaccepted requests are held stable until ready.
    model_chk = 1'b1;
    c_v = 0; c_we = 0; c_a = '0; c_w = '0; d_v = 0; d_we = 0; d_a = '0; d_w = '0;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 39) == 0);
      if (!c_v || s_cr) begin
        c_v = ($urandom_range(0, 3) != 0); c_we = $urandom_range(0, 1) == 1;
        c_a = AW'($urandom_range(0, 7)); c_w = $urandom;
      end
      if (!d_v || s_dr) begin
        d_v = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1) == 1;
        d_a = AW'($urandom_range(0, 7)); d_w = $urandom;
      end
      cycle(r, c_v, c_we, c_a, c_w, d_v, d_we, d_a, d_w);
    end
    cycle(0, 0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
    chk_stats("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (DATA_WIDTH x 2^ADDR_WIDTH, 1-cycle read latency) between two requesters: the CPU load/store unit (priority) and a debug/loader port.
- Sits between both requesters and the memory array. It owns mem_addr/mem_we/mem_wd and returns read data aligned to the memory's 1-cycle latency.
- A starvation counter guarantees the debug port forward progress under continuous CPU traffic.

Parameters:
- DATA_WIDTH, 32, word width of memory and data ports.
- ADDR_WIDTH, 3, word-address width (8 words).
- STARVE_LIMIT, 4, consecutive cycles dbg may be denied before a forced grant; legal range 1..15.

Ports:
- clk  input  1  clock
- nreset  input  1  reset: synchronous, active-high; clock clk
- cpu_req_valid  input  1  CPU request present
- cpu_req_we  input  1  1=store, 0=load
- cpu_req_addr  input  ADDR_WIDTH  word address
- cpu_req_wdata  input  DATA_WIDTH  store data
- cpu_req_ready  output  1  CPU request accepted this cycle
- cpu_rsp_valid  output  1  load data valid (1-cycle pulse)
- cpu_rsp_rdata  output  DATA_WIDTH  load data
- dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata  inputs  same as cpu_*  debug request
- dbg_req_ready  output  1  debug request accepted
- dbg_rsp_valid  output  1  debug load data valid
- dbg_rsp_rdata  output  DATA_WIDTH  debug load data
- mem_addr  output  ADDR_WIDTH  memory address
- mem_we  output  1  memory write enable
- mem_wd  output  DATA_WIDTH  memory write data
- mem_rd  input  DATA_WIDTH  memory read data, valid 1 cycle after address
- stat_cpu_grants  output  16  CPU grant count (optional feature)
- stat_dbg_grants  output  16  debug grant count (optional feature)

Behaviour:
- Reset (nreset==1 at posedge clk): starve_cnt=0, rsp_owner=NONE, cpu_rsp_valid=0, dbg_rsp_valid=0, both rdata=0, stats=0. While nreset==1, both ready outputs=0 and mem_we=0 (combinational gating). A read granted in the cycle reset is asserted produces no response.
- Handshake: a request transfers when valid && ready in the same cycle. ready is combinational from valid, starve_cnt and nreset. It never depends on ready of the other requester's response. At most one ready is high per cycle.
- Grant rule, evaluated each cycle:
  - force_dbg = dbg_req_valid && starve_cnt==STARVE_LIMIT.
  - force_dbg -> grant dbg.
  - else cpu_req_valid -> grant cpu.
  - else dbg_req_valid -> grant dbg.
  - else no grant.
- Memory drive: mem_addr/mem_wd come from the granted requester. mem_we = granted && req_we. With no grant, mem_addr = cpu_req_addr and mem_we=0.
- Starvation counter:
  - dbg_req_valid && !dbg granted -> starve_cnt+1, saturating at STARVE_LIMIT.
  - dbg granted or dbg_req_valid==0 -> starve_cnt=0.
- Read response:
  - A granted load registers rsp_owner. The next cycle, that owner's rsp_valid=1 and rsp_rdata=mem_rd for exactly one cycle.
  - rdata holds its last value otherwise.
  - Stores produce no response; their write is visible to a load granted the following cycle.
- Pipelining: a new grant is allowed every cycle, including the cycle a response is returned. Back-to-back loads yield back-to-back rsp_valid pulses. Total load latency is 1 cycle from accept to rsp_valid.
- Same-address store then load in consecutive cycles from different requesters -> the load returns the newly stored value.
- Requesters must hold req_* stable until ready. The arbiter does not latch unaccepted requests.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: stat_cpu_grants/stat_dbg_grants increment on each accepted request of that requester. Counters saturate at 16'hFFFF and clear on reset.
- Undefined: no counter registers are built; both outputs are tied to 16'h0000.

Test Plan:
- Reset, then dbg store addr 3 data 32'hDEADBEEF, then cpu load addr 3 -> cpu_rsp_valid pulses 1 cycle after the load is accepted with cpu_rsp_rdata=32'hDEADBEEF; dbg_rsp_valid stays 0.
- cpu and dbg both request loads in the same cycle with starve_cnt=0 -> cpu_req_ready=1, dbg_req_ready=0; starve_cnt=1 the next cycle.
- cpu_req_valid held high continuously, dbg load held pending, STARVE_LIMIT=4 -> dbg denied 4 cycles, granted on the 5th with cpu_req_ready=0 that cycle; starve_cnt returns to 0.
- cpu loads addr 0,1,2 on consecutive cycles (memory preloaded with 10,11,12) -> cpu_rsp_valid high for 3 consecutive cycles with rdata 10, 11, 12.
- cpu load accepted, nreset asserted the next cycle -> no cpu_rsp_valid, both ready=0, mem_we=0 during reset; starve_cnt=0 after release.
- With DMEM_ARB_STATS_EN: 3 cpu and 2 dbg accepted requests -> stat_cpu_grants=3, stat_dbg_grants=2. Without the macro, both stay 0.
